// File: rtl/pll_lock_pkg.sv
// PLL lock detector shared types and defaults.
// FSM state encoding and default window parameters.
package pll_lock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int NDIV_DEF     = 8;
  localparam int TOL_DEF      = 1;
  localparam int LOCK_N_DEF   = 4;
  localparam int UNLOCK_N_DEF = 2;
  localparam int CW_DEF       = 8;

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchronizer for a single asynchronous bit.
// Both flops clear on asynchronous active-low reset.
module pll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pll_lock_detect.sv
// Frequency lock detector: counts outclk cycles per refclk period
// and tracks good/bad windows through an ACQ/LOCKED/HOLD FSM.
module pll_lock_detect
  import pll_lock_pkg::*;
#(
  parameter int NDIV     = NDIV_DEF,
  parameter int TOL      = TOL_DEF,
  parameter int LOCK_N   = LOCK_N_DEF,
  parameter int UNLOCK_N = UNLOCK_N_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic          outclk,
  input  logic          rstb,
  input  logic          refclk,
  input  logic          en,
  output logic          lock,
  output logic [CW-1:0] cnt_meas,
  output logic          meas_valid,
  output logic [1:0]    state
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam int BW = $clog2(UNLOCK_N + 1);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] LO   = CW'(NDIV - TOL);
  localparam logic [CW-1:0] HI   = CW'(NDIV + TOL);

  logic ref_s;
  logic ref_d;
  logic ref_edge;

  pll_sync2 u_sync (
    .clk   (outclk),
    .rst_n (rstb),
    .d     (refclk),
    .q     (ref_s)
  );

  always_ff @(posedge outclk or negedge rstb) begin
    if (!rstb) begin
      ref_d    <= 1'b0;
      ref_edge <= 1'b0;
    end else begin
      ref_d    <= ref_s;
      ref_edge <= ref_s & ~ref_d;
    end
  end

  logic [CW-1:0] cnt;
  logic          armed;
  logic          sat;

  assign sat = (cnt == CMAX);

  // The first ref edge only arms the window; the partial one is dropped.
  always_ff @(posedge outclk or negedge rstb) begin
    if (!rstb) begin
      cnt        <= '0;
      armed      <= 1'b0;
      cnt_meas   <= '0;
      meas_valid <= 1'b0;
    end else if (!en) begin
      cnt        <= '0;
      armed      <= 1'b0;
      meas_valid <= 1'b0;
    end else if (ref_edge) begin
      if (armed) cnt_meas <= cnt;
      meas_valid <= armed;
      armed      <= 1'b1;
      cnt        <= CW'(1);
    end else if (sat) begin
      cnt_meas   <= CMAX;
      meas_valid <= 1'b1;
      armed      <= 1'b1;
      cnt        <= CW'(1);
    end else begin
      meas_valid <= 1'b0;
      cnt        <= cnt + CW'(1);
    end
  end

  logic good;

  assign good = (cnt_meas != CMAX) &&
                (cnt_meas >= LO) &&
                (cnt_meas <= HI);

  state_t        st;
  state_t        st_n;
  logic [GW-1:0] good_cnt;
  logic [GW-1:0] good_n;
  logic [BW-1:0] bad_cnt;
  logic [BW-1:0] bad_n;
  logic          lock_n;

  always_comb begin
    st_n   = st;
    good_n = good_cnt;
    bad_n  = bad_cnt;
    if (!en) begin
      st_n   = IDLE;
      good_n = '0;
      bad_n  = '0;
    end else begin
      unique case (st)
        IDLE: begin
          st_n   = ACQ;
          good_n = '0;
          bad_n  = '0;
        end
        ACQ: if (meas_valid) begin
          if (!good) begin
            good_n = '0;
          end else if (good_cnt == GW'(LOCK_N - 1)) begin
            st_n   = LOCKED;
            good_n = '0;
          end else begin
            good_n = good_cnt + GW'(1);
          end
        end
        LOCKED: if (meas_valid && !good) begin
          st_n  = (UNLOCK_N > 1) ? HOLD : ACQ;
          bad_n = (UNLOCK_N > 1) ? BW'(1) : '0;
        end
        HOLD: if (meas_valid) begin
          if (good) begin
            st_n  = LOCKED;
            bad_n = '0;
          end else if (bad_cnt == BW'(UNLOCK_N - 1)) begin
            st_n   = ACQ;
            good_n = '0;
            bad_n  = '0;
          end else begin
            bad_n = bad_cnt + BW'(1);
          end
        end
        default: st_n = IDLE;
      endcase
    end
    lock_n = (st_n == LOCKED) || (st_n == HOLD);
  end

  always_ff @(posedge outclk or negedge rstb) begin
    if (!rstb) begin
      st       <= IDLE;
      good_cnt <= '0;
      bad_cnt  <= '0;
      lock     <= 1'b0;
    end else begin
      st       <= st_n;
      good_cnt <= good_n;
      bad_cnt  <= bad_n;
      lock     <= lock_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Bench for pll_lock_detect: edge-index window model checked every
// cycle, plus directed frequency/reset/enable scenarios.
`timescale 1ns/1ps
module tb_pll_lock_detect;

  localparam int NDIV     = 8;
  localparam int TOL      = 1;
  localparam int LOCK_N   = 4;
  localparam int UNLOCK_N = 2;
  localparam int CW       = 8;

  logic          outclk;
  logic          rstb;
  logic          refclk;
  logic          en;
  logic          lock;
  logic [CW-1:0] cnt_meas;
  logic          meas_valid;
  logic [1:0]    state;

  pll_lock_detect #(
    .NDIV     (NDIV),
    .TOL      (TOL),
    .LOCK_N   (LOCK_N),
    .UNLOCK_N (UNLOCK_N),
    .CW       (CW)
  ) dut (
    .outclk     (outclk),
    .rstb       (rstb),
    .refclk     (refclk),
    .en         (en),
    .lock       (lock),
    .cnt_meas   (cnt_meas),
    .meas_valid (meas_valid),
    .state      (state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial outclk = 1'b0;
  always #5 outclk = ~outclk;

  int ncyc = 0;
  always @(posedge outclk) ncyc <= ncyc + 1;

  // Refclk source: each rise schedules the outclk edge index at which
  // the window must close (3 edges to ref_edge, one more to load).
  int ref_next = 40;
  bit ref_run  = 1'b1;
  int loadq[$];

  initial begin
    int h;
    refclk = 1'b0;
    #7;
    forever begin
      if (ref_run) begin
        refclk = 1'b1;
        loadq.push_back(ncyc + 4);
        h = ref_next;
        #h;
        refclk = 1'b0;
        #h;
      end else begin
        #10;
      end
    end
  end

  function automatic bit win_good(input int v);
    return (v != 255) && (v - NDIV <= TOL) && (NDIV - v <= TOL);
  endfunction

  int m_st    = 0;
  int m_g     = 0;
  int m_b     = 0;
  int m_mv    = 0;
  int m_meas  = 0;
  int m_L     = 0;
  int m_armed = 0;
  int m_lk    = 0;

  always @(negedge outclk) begin
    int n;
    bit rf;
    n = ncyc;
    if (!rstb) begin
      m_st = 0; m_g = 0; m_b = 0; m_lk = 0;
      m_mv = 0; m_meas = 0; m_armed = 0;
      m_L = n + 1;
      loadq.delete();
    end else begin
      while (loadq.size() > 0 && loadq[0] < n) void'(loadq.pop_front());
      rf = (loadq.size() > 0 && loadq[0] == n);
      if (rf) void'(loadq.pop_front());
      if (!en) begin
        m_st = 0; m_g = 0; m_b = 0;
      end else begin
        case (m_st)
          0: begin m_st = 1; m_g = 0; m_b = 0; end
          1: if (m_mv) begin
            if (!win_good(m_meas)) m_g = 0;
            else if (m_g + 1 == LOCK_N) begin m_st = 2; m_g = 0; end
            else m_g++;
          end
          2: if (m_mv && !win_good(m_meas)) begin m_st = 3; m_b = 1; end
          default: if (m_mv) begin
            if (win_good(m_meas)) begin m_st = 2; m_b = 0; end
            else if (m_b + 1 == UNLOCK_N) begin
              m_st = 1; m_g = 0; m_b = 0;
            end else m_b++;
          end
        endcase
      end
      m_lk = (m_st >= 2) ? 1 : 0;
      if (!en) begin
        m_mv = 0; m_armed = 0; m_L = n + 1;
      end else if (rf) begin
        m_mv = m_armed;
        if (m_armed) m_meas = n - m_L;
        m_armed = 1; m_L = n;
      end else if (n - m_L == 255) begin
        m_mv = 1; m_meas = 255; m_armed = 1; m_L = n;
      end else begin
        m_mv = 0;
      end
    end
    chk("m_state", state, m_st);
    chk("m_lock", lock, m_lk);
    chk("m_valid", meas_valid, m_mv);
    chk("m_cnt", cnt_meas, m_meas);
  end

  task automatic wait_lock(input bit chk4, input string nm);
    int k = 0;
    int seen = 0;
    while (k < 2000) begin
      @(negedge outclk);
      k++;
      if (meas_valid) seen++;
      if (lock) break;
    end
    chk({nm, "_lock"}, lock, 1);
    if (chk4) chk({nm, "_nwin"}, seen, LOCK_N);
  endtask

  task automatic wait_mv(input int val, input string nm);
    int k = 0;
    bit found = 1'b0;
    while (k < 700 && !found) begin
      @(negedge outclk);
      k++;
      if (meas_valid && cnt_meas == CW'(val)) found = 1'b1;
    end
    chk(nm, found, 1);
  endtask

  initial begin
    int k;
    rstb = 1'b0;
    en   = 1'b0;
    #22;
    chk("rst_state", state, 0);
    chk("rst_lock", lock, 0);
    chk("rst_cnt", cnt_meas, 0);
    chk("rst_valid", meas_valid, 0);
    repeat (3) @(negedge outclk);
    #1 rstb = 1'b1;
    repeat (2) @(negedge outclk);
    #1 en = 1'b1;

    wait_lock(1'b1, "acq");
    chk("acq_cnt", cnt_meas, 8);
    chk("acq_state", state, 2);

    @(posedge refclk);
    #1 ref_next = 50;
    wait_mv(10, "slow_w1");
    @(negedge outclk);
    chk("slow_hold", state, 3);
    chk("slow_hold_lock", lock, 1);
    wait_mv(10, "slow_w2");
    @(negedge outclk);
    chk("slow_acq", state, 1);
    chk("slow_acq_lock", lock, 0);
    ref_next = 40;
    wait_lock(1'b0, "relock1");

    @(posedge refclk);
    #1 ref_next = 45;
    @(posedge refclk);
    #1 ref_next = 40;
    wait_mv(9, "tol_w9");
    @(negedge outclk);
    chk("tol_state", state, 2);
    chk("tol_lock", lock, 1);
    wait_mv(8, "tol_w8a");
    wait_mv(8, "tol_w8b");
    chk("tol_state2", state, 2);

    @(posedge refclk);
    #1 ref_run = 1'b0;
    wait_mv(255, "sat_w1");
    k = 0;
    do begin
      @(negedge outclk);
      k++;
    end while (!meas_valid && k < 600);
    chk("sat_period", k, 255);
    chk("sat_cnt", cnt_meas, 255);
    @(negedge outclk);
    chk("sat_state", state, 1);
    chk("sat_lock", lock, 0);
    ref_run = 1'b1;
    wait_lock(1'b0, "relock2");

    @(negedge refclk);
    #11 rstb = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_lock", lock, 0);
    chk("arst_cnt", cnt_meas, 0);
    chk("arst_valid", meas_valid, 0);
    repeat (2) @(negedge outclk);
    #1 rstb = 1'b1;
    wait_lock(1'b1, "relock_rst");

    @(negedge outclk);
    #1 en = 1'b0;
    @(negedge outclk);
    chk("en_off_state", state, 0);
    chk("en_off_lock", lock, 0);
    repeat (20) @(negedge outclk);
    #1 en = 1'b1;
    wait_lock(1'b1, "relock_en");

    repeat (5) @(negedge outclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
